// File: rtl/alu_exec_stage_pkg.sv
// Shared op-code encoding and width defaults for the ALU execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_exec_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W_DEF = 5;
  localparam int OP_W     = 4;
  localparam int SHAMT_W  = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational integer ALU: op, a, b -> result plus undefined-op flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns all handshaking.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;

  assign shamt = b[SHAMT_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Decode the op; undefined codes yield a zero result and raise illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << shamt;
      OP_SLT:  result = XLEN'(lt_s);
      OP_SLTU: result = XLEN'(lt_u);
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Single-entry registered ALU execute stage between decode and writeback.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, so a draining entry reloads with no bubble.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;
  logic            take_in;

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .op      (in_op),
    .a       (in_a),
    .b       (in_b),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign take_in  = in_valid && in_ready;

  // Output register: reset beats flush, flush beats handshakes; a flush only drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take_in) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_rd      <= in_rd;
      out_illegal <= alu_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
